clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_chan.sv | 45 ++++
 rtl/clk_div_multi.sv | 36 +++
 tb/tb_clk_div_multi.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and per-channel state record for clk_div_multi
package clk_div_pkg;
  localparam int DIV_MIN = 2;
  localparam int DEF_DIV = 4;
  localparam int CH_W = 3;
  typedef struct packed {
    logic running;
    logic pending;
  } chan_flags_t;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one glitch-free divider channel; ports clk, reset(active-low), en, sync, wr/div (decoded write), clk_out, tick
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] div,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] d, p, cnt, cnt_nx, d_nx, h;
  chan_flags_t st;
  logic wrap, live;
  always_comb begin
    live = en && st.running;
    wrap = !st.running || cnt == d - CNT_W'(1) || sync;
    cnt_nx = (!en || wrap) ? '0 : cnt + CNT_W'(1);
    d_nx = (en && wrap && st.pending) ? p : d;
    h = (d_nx >> 1) + CNT_W'(d_nx[0]);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      d <= CNT_W'(DEF_DIV);
      p <= CNT_W'(DEF_DIV);
      cnt <= '0;
      st <= '0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      clk_out <= en && cnt_nx < h;
      tick <= en && cnt_nx == '0;
      st.running <= en;
      d <= (wr && !live) ? div : d_nx;
      p <= (wr && live) ? div : p;
      st.pending <= wr ? live : st.pending && !(en && wrap);
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent clock dividers with shared sync and divisor write port
// ports: clk, reset(sync active-low), en[NUM_CH], sync, cfg_wr/cfg_ch/cfg_div, cfg_err, clk_out[NUM_CH], tick[NUM_CH]
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 16,
  parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  logic valid;
  assign valid = int'(cfg_ch) < NUM_CH && cfg_div >= CNT_W'(DIV_MIN);
  always_ff @(posedge clk) cfg_err <= reset && cfg_wr && !valid;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_chan (
      .clk(clk),
      .reset(reset),
      .en(en[c]),
      .sync(sync),
      .wr(cfg_wr && valid && cfg_ch == CH_W'(c)),
      .div(cfg_div),
      .clk_out(clk_out[c]),
      .tick(tick[c])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized and directed check of clk_div_multi against a behavioural model
module tb_clk_div_multi;
  localparam int N = 2, W = 16;
  logic clk = 1'b0;
  logic reset, sync, cfg_wr, cfg_err;
  logic [N-1:0] en, clk_out, tick;
  logic [2:0] cfg_ch;
  logic [W-1:0] cfg_div;
  logic r2, wr2, err2;
  logic [0:0] en2, co2, tk2;
  logic [2:0] ch2, div2;
  int n_chk = 0, n_fail = 0;
  int md[N], mp[N], mcnt[N];
  bit mpend[N], mrun[N], m_co[N], m_tk[N], m_err;
  clk_div_multi #(.NUM_CH(N), .CNT_W(W), .DEF_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick)
  );
  clk_div_multi #(.NUM_CH(1), .CNT_W(3), .DEF_DIV(4)) dut2 (
    .clk(clk), .reset(r2), .en(en2), .sync(1'b0), .cfg_wr(wr2), .cfg_ch(ch2),
    .cfg_div(div2), .cfg_err(err2), .clk_out(co2), .tick(tk2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step();
    bit ok, w, was, wrap;
    ok = cfg_wr && cfg_ch < N && cfg_div >= 2;
    if (!reset) begin
      m_err = 0;
      for (int i = 0; i < N; i++) begin
        md[i] = 4; mp[i] = 4; mcnt[i] = 0; mpend[i] = 0; mrun[i] = 0; m_co[i] = 0; m_tk[i] = 0;
      end
    end else begin
      m_err = cfg_wr && !ok;
      for (int i = 0; i < N; i++) begin
        w = ok && cfg_ch == i;
        was = en[i] && mrun[i];
        if (en[i]) begin
          wrap = !mrun[i] || mcnt[i] == md[i] - 1 || sync;
          if (wrap && mpend[i]) begin md[i] = mp[i]; mpend[i] = 0; end
          mcnt[i] = wrap ? 0 : mcnt[i] + 1;
          mrun[i] = 1;
        end else begin
          mcnt[i] = 0;
          mrun[i] = 0;
        end
        if (w && was) begin mp[i] = int'(cfg_div); mpend[i] = 1; end
        else if (w) begin md[i] = int'(cfg_div); mpend[i] = 0; end
        m_co[i] = en[i] && mcnt[i] < (md[i] + 1) / 2;
        m_tk[i] = en[i] && mcnt[i] == 0;
      end
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("clk_out[%0d]", i), 32'(clk_out[i]), 32'(m_co[i]));
      chk($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(m_tk[i]));
    end
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    cfg_wr = 0;
    sync = 0;
  endtask
  task automatic wr(input int ch, input int dv);
    cfg_wr = 1; cfg_ch = 3'(ch); cfg_div = W'(dv);
  endtask
  initial begin
    int e_co[9], e_tk[9];
    reset = 0; en = 0; sync = 0; cfg_wr = 0; cfg_ch = 0; cfg_div = 0;
    r2 = 0; en2 = 0; wr2 = 0; ch2 = 0; div2 = 0;
    repeat (2) cycle();
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_err", 32'(cfg_err), 0);
    reset = 1; en = 2'b01;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("p1_clk0", 32'(clk_out[0]), 32'((k % 4) < 2));
      chk("p1_tick0", 32'(tick[0]), 32'(k % 4 == 0));
      chk("p1_ch1", 32'(clk_out[1]), 0);
    end
    en = 0; wr(0, 5); cycle();
    e_co = '{1, 1, 1, 0, 0, 1, 0, 1, 0};
    e_tk = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
    en = 2'b01;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) wr(0, 2);
      cycle();
      chk("p2_clk0", 32'(clk_out[0]), e_co[k]);
      chk("p2_tick0", 32'(tick[0]), e_tk[k]);
    end
    wr(0, 1); cycle(); chk("err_div1", 32'(cfg_err), 1);
    cycle(); chk("err_clear", 32'(cfg_err), 0);
    wr(5, 3); cycle(); chk("err_ch5", 32'(cfg_err), 1);
    cycle(); chk("err_clear2", 32'(cfg_err), 0);
    en = 0; wr(0, 4); cycle(); wr(1, 6); cycle();
    en = 2'b01; repeat (2) cycle();
    en = 2'b11; repeat (5) cycle();
    sync = 1; cycle();
    chk("sync_tick", 32'(tick), 3);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("sync_t0", 32'(tick[0]), 32'(k % 4 == 0));
      chk("sync_t1", 32'(tick[1]), 32'(k % 6 == 0));
    end
    for (int k = 0; k < 8 && mcnt[0] != 3; k++) cycle();
    chk("wrap_wait", mcnt[0], 3);
    wr(0, 3); cycle();
    chk("coinc_tick", 32'(tick[0]), 1);
    e_co = '{1, 0, 0, 1, 1, 0, 1, 1, 0};
    e_tk = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("coinc_clk0", 32'(clk_out[0]), e_co[k]);
      chk("coinc_tick0", 32'(tick[0]), e_tk[k]);
    end
    wr(0, 7); cycle(); cycle();
    reset = 0; wr(1, 9); sync = 1; cycle();
    chk("mid_rst_clk", 32'(clk_out), 0);
    chk("mid_rst_tick", 32'(tick), 0);
    reset = 1; en = 2'b01;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("post_rst_clk0", 32'(clk_out[0]), 32'((k % 4) < 2));
    end
    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(0, 199) != 0;
      if ($urandom_range(0, 19) == 0) en = N'($urandom);
      sync = $urandom_range(0, 29) == 0;
      cfg_wr = $urandom_range(0, 5) == 0;
      cfg_ch = 3'($urandom_range(0, 3));
      cfg_div = W'($urandom_range(0, 9));
      cycle();
    end
    @(posedge clk); #1;
    r2 = 1; wr2 = 1; ch2 = 0; div2 = 3'd7;
    @(posedge clk); #1;
    wr2 = 0; en2 = 1;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      chk("max_clk", 32'(co2), 32'((k % 7) < 4));
      chk("max_tick", 32'(tk2), 32'(k % 7 == 0));
    end
    chk("max_err", 32'(err2), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
